ast_width_upsizer: RTL and testbench

//  Avalon-ST bus-width up-converter: packs N = DATA_OUT_W/DATA_IN_W narrow beats into one wide word.
//  Any integer ratio is supported. Carries channel, start/end-of-packet and empty (byte count).

---
 rtl/ast_width_upsizer.sv | 248 ++++++++++++++++++++++++
 tb/tb_ast_width_upsizer.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ast_width_upsizer.sv
// -----------------------------------------------------------------------------
// ast_width_upsizer
//
// Avalon-ST width up-converter. Packs N = DATA_OUT_W/DATA_IN_W narrow beats
// into one wide word, first beat in the MSBs. Channel, start/end-of-packet
// and empty are carried through. Malformed packets (missing sop or eop) are
// recovered from, and each violation raises a one-cycle err_o pulse.
//
// Ports
//   clk_i                clock
//   rst_i                asynchronous active-high reset
//   ast_data_i           narrow input beat
//   ast_startofpacket_i  first beat of a packet
//   ast_endofpacket_i    last beat of a packet
//   ast_valid_i          input beat valid
//   ast_empty_i          unused LSB bytes of the eop beat
//   ast_channel_i        packet channel, sampled on the sop beat only
//   ast_ready_o          block accepts a beat this cycle
//   ast_data_o           packed wide word
//   ast_startofpacket_o  first word of a packet
//   ast_endofpacket_o    last word of a packet
//   ast_valid_o          output word valid
//   ast_empty_o          unused LSB bytes of the output word
//   ast_channel_o        latched packet channel
//   ast_ready_i          sink accepts the word
//   err_o                one-cycle pulse on a protocol violation
// -----------------------------------------------------------------------------
module ast_width_upsizer #(
   parameter int DATA_IN_W   = 64,
   parameter int DATA_OUT_W  = 128,
   parameter int CHANNEL_W   = 10,
   parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1)  ? $clog2(DATA_IN_W / 8)  : 1,
   parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [DATA_IN_W-1:0]   ast_data_i,
   input  logic                   ast_startofpacket_i,
   input  logic                   ast_endofpacket_i,
   input  logic                   ast_valid_i,
   input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
   input  logic [CHANNEL_W-1:0]   ast_channel_i,
   output logic                   ast_ready_o,
   output logic [DATA_OUT_W-1:0]  ast_data_o,
   output logic                   ast_startofpacket_o,
   output logic                   ast_endofpacket_o,
   output logic                   ast_valid_o,
   output logic [EMPTY_OUT_W-1:0] ast_empty_o,
   output logic [CHANNEL_W-1:0]   ast_channel_o,
   input  logic                   ast_ready_i,
   output logic                   err_o
);

   localparam int N        = DATA_OUT_W / DATA_IN_W;
   localparam int BYTES_IN = DATA_IN_W / 8;
   localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam int PAD_W    = DATA_OUT_W - DATA_IN_W;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PKT  = 1'b1
   } state_t;

   // packing state
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_OUT_W-1:0]  acc_q, acc_d;
   logic [CHANNEL_W-1:0]   chan_q, chan_d;
   logic                   first_q, first_d;      // next emitted word is the packet's first
   // A sop+eop beat that arrives while a partial word is being flushed
   // completes a second word in the same cycle. It is parked in the
   // accumulator and emitted on the following free output cycle.
   logic                   pend_q, pend_d;
   logic [EMPTY_OUT_W-1:0] pend_empty_q, pend_empty_d;

   // output register
   logic [DATA_OUT_W-1:0]  data_q, data_d;
   logic                   sop_q, sop_d;
   logic                   eop_q, eop_d;
   logic                   valid_q, valid_d;
   logic [EMPTY_OUT_W-1:0] empty_q, empty_d;
   logic [CHANNEL_W-1:0]   chan_o_q, chan_o_d;
   logic                   err_q, err_d;

   logic                   out_free;
   logic                   beat_acc;
   logic [DATA_OUT_W-1:0]  merged;       // accumulator with the beat in slot cnt_q
   logic [DATA_OUT_W-1:0]  slot0_word;   // beat alone in slot 0, rest zero

   // combinational scratch for the next-state process
   logic                   start;
   logic                   flush;
   logic                   completes;
   logic                   first_sel;
   logic [CHANNEL_W-1:0]   chan_sel;
   logic [CNT_W-1:0]       idx;
   logic [DATA_OUT_W-1:0]  word;
   logic [EMPTY_OUT_W-1:0] eop_empty;
   logic [EMPTY_OUT_W-1:0] flush_empty;

   assign out_free    = ~valid_q | ast_ready_i;
   assign ast_ready_o = out_free & ~pend_q;
   assign beat_acc    = ast_valid_i & ast_ready_o;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_slot
         assign merged[DATA_OUT_W-1-gi*DATA_IN_W -: DATA_IN_W] =
            (cnt_q == CNT_W'(gi)) ? ast_data_i
                                  : acc_q[DATA_OUT_W-1-gi*DATA_IN_W -: DATA_IN_W];
      end
   endgenerate

   assign slot0_word = DATA_OUT_W'(ast_data_i) << PAD_W;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      chan_d       = chan_q;
      first_d      = first_q;
      pend_d       = pend_q;
      pend_empty_d = pend_empty_q;
      data_d       = data_q;
      sop_d        = sop_q;
      eop_d        = eop_q;
      empty_d      = empty_q;
      chan_o_d     = chan_o_q;
      valid_d      = valid_q & ~ast_ready_i;
      err_d        = 1'b0;

      start       = ast_startofpacket_i;
      flush       = 1'b0;
      idx         = ast_startofpacket_i ? '0 : cnt_q;
      word        = ast_startofpacket_i ? slot0_word : merged;
      first_sel   = ast_startofpacket_i | first_q;
      chan_sel    = ast_startofpacket_i ? ast_channel_i : chan_q;
      completes   = ast_endofpacket_i | (idx == LAST_SLOT);
      eop_empty   = EMPTY_OUT_W'((N - 1 - int'(idx)) * BYTES_IN + int'(ast_empty_i));
      flush_empty = EMPTY_OUT_W'((N - int'(cnt_q)) * BYTES_IN);

      if (pend_q) begin
         if (out_free) begin
            data_d   = acc_q;
            sop_d    = 1'b1;
            eop_d    = 1'b1;
            empty_d  = pend_empty_q;
            chan_o_d = chan_q;
            valid_d  = 1'b1;
            acc_d    = '0;
            pend_d   = 1'b0;
         end
      end else if (beat_acc) begin
         if ((state_q == S_IDLE) && !ast_startofpacket_i) begin
            // stray beat outside a packet: dropped
            err_d = 1'b1;
         end else begin
            if (start && (state_q == S_PKT)) begin
               // previous packet never saw its eop
               err_d = 1'b1;
               flush = (cnt_q != '0);
            end

            if (flush) begin
               data_d   = acc_q;
               sop_d    = first_q;
               eop_d    = 1'b1;
               empty_d  = flush_empty;
               chan_o_d = chan_q;
               valid_d  = 1'b1;
            end

            chan_d = chan_sel;

            if (!completes) begin
               acc_d   = word;
               cnt_d   = idx + CNT_W'(1);
               first_d = first_sel;
               state_d = S_PKT;
            end else if (flush) begin
               // flush implies N >= 2 and idx == 0, so completion here
               // can only come from eop on the new sop beat
               acc_d        = word;
               pend_d       = 1'b1;
               pend_empty_d = eop_empty;
               cnt_d        = '0;
               first_d      = 1'b1;
               state_d      = S_IDLE;
            end else begin
               data_d   = word;
               sop_d    = first_sel;
               eop_d    = ast_endofpacket_i;
               empty_d  = ast_endofpacket_i ? eop_empty : '0;
               chan_o_d = chan_sel;
               valid_d  = 1'b1;
               acc_d    = '0;
               cnt_d    = '0;
               first_d  = ast_endofpacket_i;
               state_d  = ast_endofpacket_i ? S_IDLE : S_PKT;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         chan_q       <= '0;
         first_q      <= 1'b0;
         pend_q       <= 1'b0;
         pend_empty_q <= '0;
         data_q       <= '0;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
         valid_q      <= 1'b0;
         empty_q      <= '0;
         chan_o_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         chan_q       <= chan_d;
         first_q      <= first_d;
         pend_q       <= pend_d;
         pend_empty_q <= pend_empty_d;
         data_q       <= data_d;
         sop_q        <= sop_d;
         eop_q        <= eop_d;
         valid_q      <= valid_d;
         empty_q      <= empty_d;
         chan_o_q     <= chan_o_d;
         err_q        <= err_d;
      end
   end

   assign ast_data_o          = data_q;
   assign ast_startofpacket_o = sop_q;
   assign ast_endofpacket_o   = eop_q;
   assign ast_valid_o         = valid_q;
   assign ast_empty_o         = empty_q;
   assign ast_channel_o       = chan_o_q;
   assign err_o               = err_q;

endmodule

// File: tb/tb_ast_width_upsizer.sv
`timescale 1ns/1ps
module tb_ast_width_upsizer;

   localparam int DIW = 64;
   localparam int DOW = 128;
   localparam int CW  = 10;
   localparam int EIW = 3;
   localparam int EOW = 4;
   localparam int N   = DOW / DIW;
   localparam int BPB = DIW / 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [DIW-1:0] ast_data_i = '0;
   logic           ast_sop_i = 1'b0;
   logic           ast_eop_i = 1'b0;
   logic           ast_valid_i = 1'b0;
   logic [EIW-1:0] ast_empty_i = '0;
   logic [CW-1:0]  ast_channel_i = '0;
   logic           ast_ready_o;
   logic [DOW-1:0] ast_data_o;
   logic           ast_sop_o;
   logic           ast_eop_o;
   logic           ast_valid_o;
   logic [EOW-1:0] ast_empty_o;
   logic [CW-1:0]  ast_channel_o;
   logic           ast_ready_i = 1'b1;
   logic           err_o;

   always #5 clk = ~clk;

   ast_width_upsizer #(
      .DATA_IN_W(DIW), .DATA_OUT_W(DOW), .CHANNEL_W(CW), .EMPTY_IN_W(EIW), .EMPTY_OUT_W(EOW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_sop_i), .ast_endofpacket_i(ast_eop_i),
      .ast_valid_i(ast_valid_i), .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i),
      .ast_ready_o(ast_ready_o),
      .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_sop_o), .ast_endofpacket_o(ast_eop_o),
      .ast_valid_o(ast_valid_o), .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o),
      .ast_ready_i(ast_ready_i), .err_o(err_o)
   );

   typedef struct {
      logic [DOW-1:0] data;
      logic           sop;
      logic           eop;
      logic [EOW-1:0] empty;
      logic [CW-1:0]  chan;
   } word_t;

   word_t exp_q[$];
   word_t got_q[$];
   word_t mon_g, mon_e;
   int checks = 0;
   int failures = 0;
   int err_seen = 0;
   int exp_err = 0;
   int ready_mode = 0;   // 0: always ready, 1: random, 2: held low

   // reference model: packets as lists of beats
   bit             m_open = 1'b0;
   bit             m_first = 1'b0;
   logic [CW-1:0]  m_chan = '0;
   logic [DIW-1:0] m_beats[$];

   task automatic m_emit(input bit eop, input int extra_empty);
      word_t w;
      w.data = '0;
      for (int k = 0; k < m_beats.size(); k++) w.data[DOW-1-k*DIW -: DIW] = m_beats[k];
      w.sop   = m_first;
      w.eop   = eop;
      w.empty = EOW'((N - m_beats.size()) * BPB + extra_empty);
      w.chan  = m_chan;
      exp_q.push_back(w);
      m_first = 1'b0;
      m_beats.delete();
      if (eop) m_open = 1'b0;
   endtask

   task automatic model_beat(input logic [DIW-1:0] d, input bit sop, input bit eop,
                             input logic [EIW-1:0] emp, input logic [CW-1:0] ch);
      if (!m_open && !sop) begin
         exp_err++;
         return;
      end
      if (sop) begin
         if (m_open) begin
            exp_err++;
            if (m_beats.size() > 0) m_emit(1'b1, 0);
         end
         m_open  = 1'b1;
         m_first = 1'b1;
         m_chan  = ch;
         m_beats.delete();
      end
      m_beats.push_back(d);
      if (eop) m_emit(1'b1, int'(emp));
      else if (m_beats.size() == N) m_emit(1'b0, 0);
   endtask

   // sink ready driver
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       ast_ready_i = 1'b1;
            1:       ast_ready_i = 1'($urandom_range(0, 1));
            default: ast_ready_i = 1'b0;
         endcase
      end
   end

   // output monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (err_o) err_seen++;
         if (ast_valid_o && ast_ready_i) begin
            mon_g.data  = ast_data_o;
            mon_g.sop   = ast_sop_o;
            mon_g.eop   = ast_eop_o;
            mon_g.empty = ast_empty_o;
            mon_g.chan  = ast_channel_o;
            got_q.push_back(mon_g);
            $display("word data=%h sop=%0b eop=%0b empty=%0d chan=%h",
                     mon_g.data, mon_g.sop, mon_g.eop, mon_g.empty, mon_g.chan);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL word_unexpected got data=%h sop=%0b eop=%0b empty=%0d, none required",
                        mon_g.data, mon_g.sop, mon_g.eop, mon_g.empty);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_g.data !== mon_e.data || mon_g.sop !== mon_e.sop || mon_g.eop !== mon_e.eop ||
                   mon_g.empty !== mon_e.empty || mon_g.chan !== mon_e.chan) begin
                  failures++;
                  $display("FAIL word_match got %h/%0b/%0b/%0d/%h required %h/%0b/%0b/%0d/%h",
                           mon_g.data, mon_g.sop, mon_g.eop, mon_g.empty, mon_g.chan,
                           mon_e.data, mon_e.sop, mon_e.eop, mon_e.empty, mon_e.chan);
               end
            end
         end
      end
   end

   task automatic send_beat(input logic [DIW-1:0] d, input bit sop, input bit eop,
                            input logic [EIW-1:0] emp, input logic [CW-1:0] ch);
      int  n = 0;
      bit  ok = 1'b1;
      ast_data_i = d; ast_sop_i = sop; ast_eop_i = eop; ast_empty_i = emp; ast_channel_i = ch;
      ast_valid_i = 1'b1;
      forever begin
         @(negedge clk);
         if (ast_ready_o) break;
         n++;
         if (n > 200) begin
            checks++; failures++; ok = 1'b0;
            $display("FAIL beat_accept_timeout ready_o stayed %0b, required 1", ast_ready_o);
            break;
         end
      end
      @(posedge clk);
      #1;
      ast_valid_i = 1'b0;
      if (ok) model_beat(d, sop, eop, emp, ch);
   endtask

   task automatic idle(input int n);
      ast_valid_i = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !ast_valid_o) begin
            ok = 1'b1;
            break;
         end
      end
      idle(3);
   endtask

   function automatic logic [DIW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (ast_valid_o !== 1'b0 || ast_data_o !== '0) begin
         failures++;
         $display("FAIL reset_data got valid=%0b data=%h required 0", ast_valid_o, ast_data_o);
      end
      checks++;
      if ({ast_sop_o, ast_eop_o, ast_empty_o, ast_channel_o, err_o} !== '0) begin
         failures++;
         $display("FAIL reset_flags got sop=%0b eop=%0b empty=%0d chan=%h err=%0b required 0",
                  ast_sop_o, ast_eop_o, ast_empty_o, ast_channel_o, err_o);
      end
      checks++;
      if (ast_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got %0b required 1", ast_ready_o);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_basic_packing();
      logic [DIW-1:0] a = rnd64(), b = rnd64(), c = rnd64(), d = rnd64();
      int  base = got_q.size();
      bit  ok;
      ready_mode = 0;
      send_beat(a, 1, 0, 0, 10'h2A);
      send_beat(b, 0, 0, 0, 10'h2A);
      send_beat(c, 0, 0, 0, 10'h2A);
      send_beat(d, 0, 1, 0, 10'h2A);
      drain(ok);
      checks++;
      if (!ok || got_q.size() - base !== 2) begin
         failures++;
         $display("FAIL basic_count got %0d words required 2", got_q.size() - base);
      end else begin
         checks++;
         if (got_q[base].data !== {a, b} || got_q[base].sop !== 1'b1 || got_q[base].eop !== 1'b0 ||
             got_q[base].empty !== 4'd0) begin
            failures++;
            $display("FAIL basic_word0 got %h sop=%0b eop=%0b empty=%0d required %h 1 0 0",
                     got_q[base].data, got_q[base].sop, got_q[base].eop, got_q[base].empty, {a, b});
         end
         checks++;
         if (got_q[base+1].data !== {c, d} || got_q[base+1].sop !== 1'b0 ||
             got_q[base+1].eop !== 1'b1 || got_q[base+1].empty !== 4'd0) begin
            failures++;
            $display("FAIL basic_word1 got %h sop=%0b eop=%0b empty=%0d required %h 0 1 0",
                     got_q[base+1].data, got_q[base+1].sop, got_q[base+1].eop,
                     got_q[base+1].empty, {c, d});
         end
      end
   endtask

   task automatic test_partial_and_single();
      logic [DIW-1:0] a = rnd64(), b = rnd64(), c = rnd64(), s = rnd64();
      int  base = got_q.size();
      bit  ok;
      send_beat(a, 1, 0, 0, 10'h011);
      send_beat(b, 0, 0, 0, 10'h011);
      send_beat(c, 0, 1, 3, 10'h011);
      send_beat(s, 1, 1, 2, 10'h155);
      drain(ok);
      checks++;
      if (!ok || got_q.size() - base !== 3) begin
         failures++;
         $display("FAIL partial_count got %0d words required 3", got_q.size() - base);
      end else begin
         checks++;
         if (got_q[base+1].data !== {c, 64'h0} || got_q[base+1].eop !== 1'b1 ||
             got_q[base+1].empty !== 4'd11) begin
            failures++;
            $display("FAIL partial_empty got %h eop=%0b empty=%0d required %h 1 11",
                     got_q[base+1].data, got_q[base+1].eop, got_q[base+1].empty, {c, 64'h0});
         end
         checks++;
         if (got_q[base+2].data !== {s, 64'h0} || got_q[base+2].sop !== 1'b1 ||
             got_q[base+2].eop !== 1'b1 || got_q[base+2].empty !== 4'd10 ||
             got_q[base+2].chan !== 10'h155) begin
            failures++;
            $display("FAIL single_beat got sop=%0b eop=%0b empty=%0d chan=%h required 1 1 10 155",
                     got_q[base+2].sop, got_q[base+2].eop, got_q[base+2].empty, got_q[base+2].chan);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DIW-1:0] v[6];
      int  base = got_q.size();
      bit  ok;
      for (int i = 0; i < 6; i++) v[i] = rnd64();
      ready_mode = 2;
      send_beat(v[0], 1, 0, 0, 10'h0F0);
      send_beat(v[1], 0, 0, 0, 10'h0F0);
      ast_data_i = v[2]; ast_sop_i = 1'b0; ast_eop_i = 1'b0; ast_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (ast_ready_o !== 1'b0 || ast_valid_o !== 1'b1 || ast_data_o !== {v[0], v[1]} ||
             ast_sop_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold cycle %0d got ready=%0b valid=%0b data=%h required 0 1 %h",
                     i, ast_ready_o, ast_valid_o, ast_data_o, {v[0], v[1]});
         end
      end
      @(posedge clk);
      #1;
      ready_mode = 0;
      for (int i = 2; i < 6; i++) send_beat(v[i], 0, i == 5, 0, 10'h0F0);
      drain(ok);
      checks++;
      if (!ok || got_q.size() - base !== 3) begin
         failures++;
         $display("FAIL stall_count got %0d words required 3", got_q.size() - base);
      end else begin
         checks++;
         if (got_q[base+2].data !== {v[4], v[5]} || got_q[base+2].eop !== 1'b1) begin
            failures++;
            $display("FAIL stall_order got %h eop=%0b required %h 1",
                     got_q[base+2].data, got_q[base+2].eop, {v[4], v[5]});
         end
      end
   endtask

   task automatic test_missing_eop();
      logic [DIW-1:0] a = rnd64(), e = rnd64(), f = rnd64();
      int  base = got_q.size();
      int  ebase = err_seen;
      bit  ok;
      send_beat(a, 1, 0, 0, 10'h001);
      send_beat(e, 1, 0, 0, 10'h002);
      send_beat(f, 0, 1, 0, 10'h003);
      drain(ok);
      checks++;
      if (!ok || got_q.size() - base !== 2) begin
         failures++;
         $display("FAIL flush_count got %0d words required 2", got_q.size() - base);
      end else begin
         checks++;
         if (got_q[base].data !== {a, 64'h0} || got_q[base].eop !== 1'b1 ||
             got_q[base].empty !== 4'd8) begin
            failures++;
            $display("FAIL flush_word got %h eop=%0b empty=%0d required %h 1 8",
                     got_q[base].data, got_q[base].eop, got_q[base].empty, {a, 64'h0});
         end
         checks++;
         if (got_q[base+1].data !== {e, f} || got_q[base+1].sop !== 1'b1 ||
             got_q[base+1].eop !== 1'b1 || got_q[base+1].chan !== 10'h002) begin
            failures++;
            $display("FAIL flush_next got %h sop=%0b eop=%0b chan=%h required %h 1 1 002",
                     got_q[base+1].data, got_q[base+1].sop, got_q[base+1].eop,
                     got_q[base+1].chan, {e, f});
         end
      end
      checks++;
      if (err_seen - ebase !== 1) begin
         failures++;
         $display("FAIL flush_err got %0d pulse cycles required 1", err_seen - ebase);
      end
   endtask

   task automatic test_err_and_reset();
      logic [DIW-1:0] a = rnd64(), b = rnd64(), c = rnd64(), g = rnd64(), h = rnd64();
      int  base = got_q.size();
      int  ebase = err_seen;
      bit  ok;
      send_beat(rnd64(), 0, 0, 0, 10'h3FF);
      idle(4);
      checks++;
      if (err_seen - ebase !== 1 || got_q.size() !== base) begin
         failures++;
         $display("FAIL stray_beat got err cycles=%0d words=%0d required 1 0",
                  err_seen - ebase, got_q.size() - base);
      end
      send_beat(a, 1, 0, 0, 10'h044);
      send_beat(b, 0, 0, 0, 10'h044);
      send_beat(c, 0, 0, 0, 10'h044);
      idle(3);
      rst = 1'b1;
      #1;
      checks++;
      if (ast_valid_o !== 1'b0 || ast_data_o !== '0 || ast_sop_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_async got valid=%0b data=%h sop=%0b required 0",
                  ast_valid_o, ast_data_o, ast_sop_o);
      end
      m_open = 1'b0;
      m_beats.delete();
      exp_q.delete();
      idle(2);
      rst = 1'b0;
      idle(1);
      base = got_q.size();
      send_beat(g, 1, 0, 0, 10'h066);
      send_beat(h, 0, 1, 0, 10'h066);
      drain(ok);
      checks++;
      if (!ok || got_q.size() - base !== 1) begin
         failures++;
         $display("FAIL post_reset_count got %0d words required 1", got_q.size() - base);
      end else begin
         checks++;
         if (got_q[base].data !== {g, h} || got_q[base].sop !== 1'b1 || got_q[base].eop !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_word got %h sop=%0b eop=%0b required %h 1 1",
                     got_q[base].data, got_q[base].sop, got_q[base].eop, {g, h});
         end
      end
   endtask

   task automatic test_random();
      int  kind, len;
      bit  ok;
      ready_mode = 1;
      for (int p = 0; p < 40; p++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            send_beat(rnd64(), 0, 0, 0, 10'($urandom));
         end else begin
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
               send_beat(rnd64(), i == 0, (kind != 1) && (i == len - 1),
                         3'($urandom_range(0, 7)), 10'($urandom));
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
         end
      end
      ready_mode = 0;
      drain(ok);
      checks++;
      if (!ok || exp_q.size() != 0) begin
         failures++;
         $display("FAIL random_drain got %0d words outstanding required 0", exp_q.size());
      end
      checks++;
      if (err_seen !== exp_err) begin
         failures++;
         $display("FAIL random_err got %0d pulses required %0d", err_seen, exp_err);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_packing();
      test_partial_and_single();
      test_backpressure();
      test_missing_eop();
      test_err_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
